// File: rtl/button_control_pkg.sv
// Shared constants and sizing helper for the button_control block.
package button_control_pkg;

  localparam int C_DEBOUNCE_TICKS = 50000;
  localparam int C_IDLE_TICKS     = 5000000;

  // Counter width able to hold 0..ticks-1, never narrower than one bit.
  function automatic int cnt_width(input int ticks);
    return ($clog2(ticks) < 1) ? 1 : $clog2(ticks);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button path: 2-FF synchroniser, debounce counter and a one-cycle press pulse
// raised when the debounced level goes 0->1.
module button_debounce
  import button_control_pkg::*;
#(
  parameter int c_debounce_ticks = C_DEBOUNCE_TICKS
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn,
  output logic press
);

  localparam int             W    = cnt_width(c_debounce_ticks);
  localparam logic [W-1:0]   TERM = W'(c_debounce_ticks - 1);

  logic [1:0]   sync;
  logic         stable;
  logic         stable_q;
  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync     <= '0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      count    <= '0;
    end else begin
      sync     <= {sync[0], btn};
      stable_q <= stable;
      // Any agreeing sample discards the run, so short glitches never land.
      if (sync[1] == stable) begin
        count <= '0;
      end else if (count == TERM) begin
        stable <= sync[1];
        count  <= '0;
      end else begin
        count <= count + W'(1);
      end
    end
  end

  assign press = stable & ~stable_q;

endmodule

// File: rtl/button_control.sv
// Two debounced push buttons, each press toggling a held level (enable / speed select).
// Optional idle auto-off of o_enable when BUTTON_CONTROL_AUTO_OFF_EN is defined.
module button_control
  import button_control_pkg::*;
#(
  parameter int   c_debounce_ticks = C_DEBOUNCE_TICKS,
  parameter int   c_idle_ticks     = C_IDLE_TICKS,
  parameter logic c_enable_init    = 1'b0,
  parameter logic c_speed_init     = 1'b0
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_btn_enable,
  input  logic i_btn_speed,
  output logic o_enable,
  output logic o_speed
);

  logic press_enable;
  logic press_speed;

  if (c_debounce_ticks < 2 || c_idle_ticks < 2) begin : g_param_check
    $error("button_control: tick parameters must be >= 2");
  end

  button_debounce #(.c_debounce_ticks(c_debounce_ticks)) u_enable (
    .clock   (i_clock),
    .reset_n (i_reset_n),
    .btn     (i_btn_enable),
    .press   (press_enable)
  );

  button_debounce #(.c_debounce_ticks(c_debounce_ticks)) u_speed (
    .clock   (i_clock),
    .reset_n (i_reset_n),
    .btn     (i_btn_speed),
    .press   (press_speed)
  );

`ifdef BUTTON_CONTROL_AUTO_OFF_EN
  localparam int            IW        = cnt_width(c_idle_ticks);
  localparam logic [IW-1:0] IDLE_TERM = IW'(c_idle_ticks - 1);

  logic [IW-1:0] idle;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      o_enable <= c_enable_init;
      o_speed  <= c_speed_init;
      idle     <= '0;
    end else begin
      o_speed <= o_speed ^ press_speed;
      // A press on the timeout edge wins: the timer restarts instead of firing.
      if (press_enable || press_speed) begin
        o_enable <= o_enable ^ press_enable;
        idle     <= '0;
      end else if (o_enable) begin
        if (idle == IDLE_TERM) begin
          o_enable <= 1'b0;
          idle     <= '0;
        end else begin
          idle <= idle + IW'(1);
        end
      end
    end
  end
`else
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      o_enable <= c_enable_init;
      o_speed  <= c_speed_init;
    end else begin
      o_enable <= o_enable ^ press_enable;
      o_speed  <= o_speed  ^ press_speed;
    end
  end
`endif

endmodule

// File: tb/tb_button_control.sv
// Randomised bench for button_control against a sample-history model of the debounce rule,
// plus directed scenarios with hand-computed timing.
module tb_button_control;

  localparam int DEB  = 4;
  localparam int IDLE = 20;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic btn_en = 1'b0;
  logic btn_sp = 1'b0;
  logic en;
  logic sp;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  button_control #(
    .c_debounce_ticks (DEB),
    .c_idle_ticks     (IDLE),
    .c_enable_init    (1'b0),
    .c_speed_init     (1'b0)
  ) dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_btn_enable (btn_en),
    .i_btn_speed  (btn_sp),
    .o_enable     (en),
    .o_speed      (sp)
  );

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: raw samples per button, newest first. A debounced level flips once the
  // synchronised samples (raw delayed two edges) differ from it for DEB edges in a row.
  int hist[2][$];
  bit m_stab[2];
  bit m_prev[2];
  bit m_en, m_sp;
  int m_idle;
  bit s_rst;
  bit s_raw[2];

  function automatic bit hv(input int b, input int i);
    return (i < hist[b].size()) ? (hist[b][i] != 0) : 1'b0;
  endfunction

  task automatic model_step();
    bit pr[2];
    bit all;
    if (!s_rst) begin
      for (int b = 0; b < 2; b++) begin
        hist[b].delete();
        m_stab[b] = 1'b0;
        m_prev[b] = 1'b0;
      end
      m_en   = 1'b0;
      m_sp   = 1'b0;
      m_idle = 0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        pr[b]     = m_stab[b] && !m_prev[b];
        m_prev[b] = m_stab[b];
        all = 1'b1;
        for (int i = 1; i <= DEB; i++) if (hv(b, i) == m_stab[b]) all = 1'b0;
        if (all) m_stab[b] = !m_stab[b];
        hist[b].push_front(int'(s_raw[b]));
        if (hist[b].size() > DEB + 2) void'(hist[b].pop_back());
      end
      m_sp = m_sp ^ pr[1];
`ifdef BUTTON_CONTROL_AUTO_OFF_EN
      if (pr[0] || pr[1]) begin
        m_en   = m_en ^ pr[0];
        m_idle = 0;
      end else if (m_en) begin
        if (m_idle == IDLE - 1) begin
          m_en   = 1'b0;
          m_idle = 0;
        end else begin
          m_idle++;
        end
      end
`else
      m_en = m_en ^ pr[0];
`endif
    end
  endtask

  // Sample inputs at the active edge, advance the model and compare on the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      s_rst    = rst_n;
      s_raw[0] = btn_en;
      s_raw[1] = btn_sp;
      @(negedge clk);
      model_step();
      check("model_en", en, m_en);
      check("model_sp", sp, m_sp);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int e, ts, td;
    logic sp0;

    // Reset and idle
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("t1_en_idle", en, 1'b0);
      check("t1_sp_idle", sp, 1'b0);
    end

    // Clean press held: exactly one toggle after edge DEB+3
    btn_en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("t2_en_latency", en, (k >= 7));
    end
    btn_en = 1'b0;
    tick(10);

    // Short speed pulses are rejected
    repeat (4) begin
      btn_sp = 1'b1;
      for (int k = 0; k < 3; k++) begin tick(); check("t3_sp_glitch", sp, 1'b0); end
      btn_sp = 1'b0;
      for (int k = 0; k < 2; k++) begin tick(); check("t3_sp_glitch", sp, 1'b0); end
    end
    tick(6);
    check("t3_sp_final", sp, 1'b0);

    // Both buttons together
    btn_en = 1'b1;
    btn_sp = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
`ifndef BUTTON_CONTROL_AUTO_OFF_EN
      check("t4_en_both", en, (k < 7));
`endif
      check("t4_sp_both", sp, (k >= 7));
    end
    btn_en = 1'b0;
    btn_sp = 1'b0;
    tick(10);

    // Button held through reset
    btn_en = 1'b1;
    tick(5);
    rst_n = 1'b0;
    tick(2);
    check("t5_en_in_reset", en, 1'b0);
    check("t5_sp_in_reset", sp, 1'b0);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("t5_en_after_rst", en, (k >= 7));
    end
    btn_en = 1'b0;
    tick(10);

`ifdef BUTTON_CONTROL_AUTO_OFF_EN
    // Auto-off with no presses
    e = 0;
    while (en && e < 40) begin tick(); e++; end
    check("t6_en_cleared", en, 1'b0);
    btn_en = 1'b1;
    e = 0;
    while (!en && e < 20) begin tick(); e++; end
    check("t6_en_on", en, 1'b1);
    btn_en = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("t6_auto_off", en, (k < 20));
    end
    tick(5);

    // Speed press restarts the idle count
    btn_en = 1'b1;
    e = 0;
    while (!en && e < 20) begin tick(); e++; end
    check("t6b_en_on", en, 1'b1);
    btn_en = 1'b0;
    sp0 = sp;
    ts = -1;
    td = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 3)  btn_sp = 1'b1;
      if (k == 12) btn_sp = 1'b0;
      if (k == 20) check("t6b_en_held", en, 1'b1);
      if (sp !== sp0 && ts < 0) ts = k;
      if (!en && td < 0) td = k;
    end
    check_int("t6b_sp_toggle_edge", ts, 10);
    check_int("t6b_restart_gap", td - ts, 20);
    tick(5);
`endif

    // Random segments of held levels around the debounce length, occasional reset
    for (int s = 0; s < 400; s++) begin
      rst_n  = ($urandom_range(0, 49) != 0);
      btn_en = 1'($urandom_range(0, 1));
      btn_sp = 1'($urandom_range(0, 1));
      tick($urandom_range(1, 9));
    end
    rst_n = 1'b1;
    btn_en = 1'b0;
    btn_sp = 1'b0;
    tick(10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
